// File: rtl/fpu_div.sv
// fpu_div: multi-cycle floating-point divider (default half precision).
// Restoring division produces one quotient bit per cycle, then rounds to
// nearest-even. Subnormal inputs are flushed to zero and subnormal results
// underflow to zero.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 request pulse, operands sampled in the same cycle
//   fpuIn1 / fpuIn2       dividend / divisor {sign, exp, frac}
//   fpuOut                registered quotient
//   done                  result valid, held until the next accepted start
//   busy                  operation in flight
//   divByZero, invalid, overflow, underflow, inexact  status, registered with fpuOut
module fpu_div #(
  parameter int FRACW = 10,
  parameter int EXPW  = 5,
  parameter int BIAS  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXPW+FRACW:0]   fpuIn1,
  input  logic [EXPW+FRACW:0]   fpuIn2,
  output logic [EXPW+FRACW:0]   fpuOut,
  output logic                  done,
  output logic                  busy,
  output logic                  divByZero,
  output logic                  invalid,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);
  localparam int W       = 1 + EXPW + FRACW;
  localparam int EXP_MAX = (1 << EXPW) - 1;
  localparam int QW      = FRACW + 3;          // integer, fraction, guard, round
  localparam int CNTW    = $clog2(QW + 1);
  localparam int EW      = EXPW + 2;           // signed working exponent
  localparam logic signed [EW-1:0] EMAX = EW'(EXP_MAX);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d, out_q, out_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [FRACW+1:0]       rem_q, rem_d;
  logic [FRACW:0]         den_q, den_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [4:0]             flg_q, flg_d;   // {divByZero, invalid, overflow, underflow, inexact}

  // Operand classification; exponent zero covers both zero and flushed subnormals.
  logic                   s1, s2, zero1, zero2, inf1, inf2, nan1, nan2;
  logic [EXPW-1:0]        e1, e2;
  logic [FRACW-1:0]       f1, f2;
  logic [FRACW:0]         m1, m2;
  logic signed [EW-1:0]   exp_raw;

  assign {s1, e1, f1} = a_q;
  assign {s2, e2, f2} = b_q;
  assign zero1   = (e1 == '0);
  assign zero2   = (e2 == '0);
  assign inf1    = (e1 == '1) && (f1 == '0);
  assign inf2    = (e2 == '1) && (f2 == '0);
  assign nan1    = (e1 == '1) && (f1 != '0);
  assign nan2    = (e2 == '1) && (f2 != '0);
  assign m1      = {1'b1, f1};
  assign m2      = {1'b1, f2};
  assign exp_raw = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(EW'(BIAS));

  // Restoring step: remainder stays below the divisor, so the shift never loses a bit.
  logic                   ge;
  logic [FRACW+1:0]       diff;
  assign ge   = (rem_q >= {1'b0, den_q});
  assign diff = rem_q - {1'b0, den_q};

  // Rounding datapath, used in ROUND.
  logic                   sticky, guard, rbit, round_up, carry, inx_r;
  logic [FRACW+1:0]       mant_rnd;
  logic [FRACW-1:0]       frac_rnd;
  logic signed [EW-1:0]   exp_fin;
  assign sticky   = |rem_q;
  assign guard    = quo_q[1];
  assign rbit     = quo_q[0];
  assign round_up = guard & (rbit | sticky | quo_q[2]);
  assign mant_rnd = {1'b0, quo_q[QW-1:2]} + {{(FRACW+1){1'b0}}, round_up};
  assign carry    = mant_rnd[FRACW+1];
  assign frac_rnd = carry ? mant_rnd[FRACW:1] : mant_rnd[FRACW-1:0];
  assign exp_fin  = exp_q + $signed({{(EW-1){1'b0}}, carry});
  assign inx_r    = guard | rbit | sticky;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    den_d   = den_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flg_d   = flg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = fpuIn1;
          b_d     = fpuIn2;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d  = s1 ^ s2;
        state_d = S_DONE;
        if (nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2)) begin
          out_d = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
          flg_d = 5'b01000;
        end else if (inf1) begin
          out_d = {s1 ^ s2, {EXPW{1'b1}}, {FRACW{1'b0}}};
          flg_d = 5'b00000;
        end else if (zero2) begin
          out_d = {s1 ^ s2, {EXPW{1'b1}}, {FRACW{1'b0}}};
          flg_d = 5'b10000;
        end else if (inf2 | zero1) begin
          out_d = {s1 ^ s2, {(W-1){1'b0}}};
          flg_d = 5'b00000;
        end else begin
          // Pre-normalize so the quotient lands in [1,2).
          state_d = S_DIVIDE;
          cnt_d   = '0;
          quo_d   = '0;
          den_d   = m2;
          if (m1 < m2) begin
            rem_d = {m1, 1'b0};
            exp_d = exp_raw - EW'(1);
          end else begin
            rem_d = {1'b0, m1};
            exp_d = exp_raw;
          end
        end
      end
      S_DIVIDE: begin
        quo_d = {quo_q[QW-2:0], ge};
        rem_d = (ge ? diff : rem_q) << 1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(QW - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (!exp_fin[EW-1] && (exp_fin >= EMAX)) begin
          out_d = {sign_q, {EXPW{1'b1}}, {FRACW{1'b0}}};
          flg_d = 5'b00101;
        end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
          out_d = {sign_q, {(W-1){1'b0}}};
          flg_d = 5'b00011;
        end else begin
          out_d = {sign_q, exp_fin[EXPW-1:0], frac_rnd};
          flg_d = {4'b0000, inx_r};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flg_q   <= flg_d;
    end
  end

  assign fpuOut = out_q;
  assign {divByZero, invalid, overflow, underflow, inexact} = flg_q;
  assign done   = (state_q == S_DONE);
  assign busy   = (state_q == S_UNPACK) || (state_q == S_DIVIDE) || (state_q == S_ROUND);
endmodule

// File: tb/tb_fpu_div.sv
module tb_fpu_div;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [15:0] fpuIn1, fpuIn2, fpuOut;
  logic        done, busy, divByZero, invalid, overflow, underflow, inexact;
  logic [4:0]  flags;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  fpu_div dut (
    .clock(clock), .reset(reset), .start(start),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOut(fpuOut),
    .done(done), .busy(busy),
    .divByZero(divByZero), .invalid(invalid), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  assign flags = {divByZero, invalid, overflow, underflow, inexact};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Half-precision reference: exact integer quotient, then round-half-even.
  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
    vec_t   r;
    int     ea, eb, fa, fb, e, rest;
    bit     sa, sb, s, za, zb, ia, ib, na, nb, sticky, up, inx;
    longint num, den, q, rm, keep;
    sa = a[15]; ea = int'(a[14:10]); fa = int'(a[9:0]);
    sb = b[15]; eb = int'(b[14:10]); fb = int'(b[9:0]);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31 && fa == 0); ib = (eb == 31 && fb == 0);
    na = (ea == 31 && fa != 0); nb = (eb == 31 && fb != 0);
    s = sa ^ sb;
    r.a = a; r.b = b; r.fl = 5'b0; r.lat = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r.out = 16'h7E00; r.fl = 5'b01000;
    end else if (ia) begin
      r.out = {s, 15'h7C00};
    end else if (zb) begin
      r.out = {s, 15'h7C00}; r.fl = 5'b10000;
    end else if (ib || za) begin
      r.out = {s, 15'h0000};
    end else begin
      r.lat = 15;
      num = longint'(1024 + fa);
      den = longint'(1024 + fb);
      e   = ea - eb + 15;
      q   = (num << 13) / den;
      if (q >= 8192) begin
        q  = (num << 12) / den;
        rm = (num << 12) % den;
      end else begin
        rm = (num << 13) % den;
        e  = e - 1;
      end
      keep   = q >> 2;
      rest   = int'(q % 4);
      sticky = (rm != 0);
      up     = (rest > 2) || (rest == 2 && (sticky || (keep % 2 == 1)));
      keep   = keep + (up ? 1 : 0);
      if (keep == 2048) begin
        keep = 1024;
        e    = e + 1;
      end
      inx = (rest != 0) || sticky;
      if (e >= 31) begin
        r.out = {s, 15'h7C00}; r.fl = 5'b00101;
      end else if (e <= 0) begin
        r.out = {s, 15'h0000}; r.fl = 5'b00011;
      end else begin
        r.out = {s, 5'(e), 10'(keep)}; r.fl = {4'b0, inx};
      end
    end
    return r;
  endfunction

  // Drive a one-cycle start; returns #1 after the sampling edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    start = 1'b1; fpuIn1 = a; fpuIn2 = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock);
      #1 n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    issue(v.a, v.b);
    chk($sformatf("%s done_drop %h/%h", tag, v.a, v.b), {31'b0, done}, 32'd0);
    wait_done(n);
    chk($sformatf("%s latency %h/%h", tag, v.a, v.b), n, v.lat);
    chk($sformatf("%s out %h/%h", tag, v.a, v.b), {16'b0, fpuOut}, {16'b0, v.out});
    chk($sformatf("%s flags %h/%h", tag, v.a, v.b), {27'b0, flags}, {27'b0, v.fl});
  endtask

  function automatic logic [15:0] rnd_op();
    int e;
    if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 1) == 1) ? 31 : 0;
    else e = int'($urandom_range(1, 30));
    return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom)};
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   n;
    tbl.push_back('{16'h4000, 16'h3C00, 16'h4000, 5'b00000, 15});
    tbl.push_back('{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15});
    tbl.push_back('{16'hC600, 16'h4000, 16'hC200, 5'b00000, 15});
    tbl.push_back('{16'h3C00, 16'h0000, 16'h7C00, 5'b10000, 1});
    tbl.push_back('{16'h0000, 16'h0000, 16'h7E00, 5'b01000, 1});
    tbl.push_back('{16'h7BFF, 16'h0400, 16'h7C00, 5'b00101, 15});
    tbl.push_back('{16'h0400, 16'h7BFF, 16'h0000, 5'b00011, 15});
    tbl.push_back('{16'h7C00, 16'h3C00, 16'h7C00, 5'b00000, 1});
    tbl.push_back('{16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 1});
    tbl.push_back('{16'h7E01, 16'h3C00, 16'h7E00, 5'b01000, 1});
    tbl.push_back('{16'h7C00, 16'hFC00, 16'h7E00, 5'b01000, 1});
    tbl.push_back('{16'h8000, 16'h3C00, 16'h8000, 5'b00000, 1});
    tbl.push_back('{16'h0001, 16'h3C00, 16'h0000, 5'b00000, 1});
    tbl.push_back('{16'hBC00, 16'h0001, 16'hFC00, 5'b10000, 1});
    tbl.push_back('{16'h7C00, 16'h0000, 16'h7C00, 5'b00000, 1});
    tbl.push_back('{16'h4400, 16'h4000, 16'h4000, 5'b00000, 15});

    // Reset state, and start held during reset must be ignored.
    reset = 1'b1; start = 1'b0; fpuIn1 = 16'h0; fpuIn2 = 16'h0;
    #12;
    chk("reset out", {16'b0, fpuOut}, 32'd0);
    chk("reset flags", {27'b0, flags}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    start = 1'b1; fpuIn1 = 16'h4000; fpuIn2 = 16'h3C00;
    repeat (2) @(posedge clock);
    #1 chk("start in reset busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("idle after reset busy", {31'b0, busy}, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], "tbl");

    // Start while busy is ignored; first result keeps its latency.
    issue(16'h4000, 16'h3C00);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1; fpuIn1 = 16'h3C00; fpuIn2 = 16'h4200;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(n);
    chk("busy start latency", n + 4, 15);
    chk("busy start out", {16'b0, fpuOut}, 32'h4000);
    chk("busy start flags", {27'b0, flags}, 32'd0);

    // Reset in the middle of DIVIDE discards the operation.
    issue(16'h3C00, 16'h4200);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("midreset out", {16'b0, fpuOut}, 32'd0);
    chk("midreset flags", {27'b0, flags}, 32'd0);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    @(negedge clock) reset = 1'b0;
    repeat (20) @(posedge clock);
    #1 chk("no done after reset", {31'b0, done}, 32'd0);
    v = '{16'h4400, 16'h4000, 16'h4000, 5'b00000, 15};
    run_vec(v, "post_reset");

    // Randomized operands against the reference model.
    for (int k = 0; k < 300; k++) begin
      v = model(rnd_op(), rnd_op());
      run_vec(v, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_div.md
FPU_DIV -- requirements
Module: fpu_div

Interface
REQ-001 SHALL have parameter FRACW, default 10, fraction width.
REQ-002 SHALL have parameter EXPW, default 5, exponent width.
REQ-003 SHALL have parameter BIAS, default 15, exponent bias; EXP_MAX = 2^EXPW-1.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request pulse; operands valid same cycle.
REQ-007 SHALL have port fpuIn1  input  1+EXPW+FRACW  dividend {sign,exp,frac}.
REQ-008 SHALL have port fpuIn2  input  1+EXPW+FRACW  divisor {sign,exp,frac}.
REQ-009 SHALL have port fpuOut  output  1+EXPW+FRACW  quotient, registered.
REQ-010 SHALL have port done  output  1  result valid; held until next accepted start.
REQ-011 SHALL have port busy  output  1  high in UNPACK, DIVIDE, ROUND.
REQ-012 SHALL have port divByZero, invalid, overflow, underflow, inexact  output  1 each  status flags, registered with fpuOut.

Function
REQ-013 SHALL implement states IDLE, UNPACK, DIVIDE, ROUND, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; accept latches fpuIn1/fpuIn2, next state UNPACK; start in other states ignored, operands untouched.
REQ-015 SHALL assert done only in DONE; done drops the cycle after a start accepted in DONE.
REQ-016 SHALL update fpuOut and all flags only on the edge entering DONE; otherwise hold prior values.
REQ-017 SHALL flush subnormal inputs to signed zero before classification (FTZ).
REQ-018 SHALL, in UNPACK, resolve specials, then go UNPACK->DONE: any NaN, 0/0, inf/inf -> 0x7E00-form qNaN (sign 0, exp max, frac MSB only), invalid=1.
REQ-019 SHALL resolve finite nonzero/0 -> signed inf, divByZero=1; inf/finite -> signed inf; finite/inf -> signed zero; 0/nonzero finite -> signed zero; no other flags.
REQ-020 SHALL compute sign = s1 XOR s2 for all non-NaN results.
REQ-021 SHALL, in UNPACK for normal operands, form mantissas {1,frac}, exponent e1-e2+BIAS in a signed EXPW+2-bit field; if m1<m2, shift m1 left 1 and decrement exponent.
REQ-022 SHALL perform restoring division in DIVIDE, one quotient bit per cycle, FRACW+3 cycles (integer, FRACW fraction, guard, round bits) via 4-bit-wide-enough cycle counter.
REQ-023 SHALL compute sticky = remainder nonzero after last iteration.
REQ-024 SHALL, in ROUND, apply round-to-nearest-even; mantissa carry-out renormalizes and increments exponent.
REQ-025 SHALL set inexact when guard|round|sticky is nonzero.
REQ-026 SHALL, if final exponent >= EXP_MAX, output signed inf with overflow=1, inexact=1.
REQ-027 SHALL, if final exponent <= 0, output signed zero with underflow=1, inexact=1 (no subnormal output).
REQ-028 SHALL present done FRACW+5 rising edges after the start-sampling edge for normal operands, 1 edge after for specials.
REQ-029 SHALL clear flags not set by the current operation.

Reset
REQ-030 SHALL, on reset at any time, go to IDLE and drive fpuOut=0, done=0, busy=0, all flags 0.
REQ-031 SHALL, on reset mid-operation, discard the operation; no done until a new start completes.
REQ-032 SHALL ignore start while reset asserted.

Verification
REQ-033 0x4000 / 0x3C00 -> fpuOut=0x4000, flags 0, done exactly 15 edges after start edge.
REQ-034 0x3C00 / 0x4200 -> 0x3555, inexact=1; then 0xC600 / 0x4000 started in DONE -> done drops, then 0xC200, inexact=0.
REQ-035 0x3C00 / 0x0000 -> 0x7C00, divByZero=1, done 1 edge after start; 0x0000 / 0x0000 -> 0x7E00, invalid=1.
REQ-036 0x7BFF / 0x0400 -> 0x7C00, overflow=1, inexact=1; 0x0400 / 0x7BFF -> 0x0000, underflow=1, inexact=1.
REQ-037 start pulse while busy with different operands -> ignored, first result delivered at original latency.
REQ-038 reset at DIVIDE cycle 5 -> outputs 0, IDLE; new start 0x4400 / 0x4000 -> 0x4000 after 15 edges.
